// File: rtl/write_frame_to_ddr3.sv
// Streams a frame from a show-ahead FIFO into one of two DDR3 frame buffers.
// Define WRITE_FRAME_STATS_EN to enable the frames_written/frames_dropped counters.
module write_frame_to_ddr3 #(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 1024
) (
    input  logic          ddr3_clk,
    input  logic          ddr3_reset_n,
    input  logic          src_sof,
    input  logic          src_burst_avail,
    input  logic [127:0]  src_data,
    output logic          src_rd,
    input  logic [25:0]   ddr3_buffer0_offset,
    input  logic [25:0]   ddr3_buffer1_offset,
    input  logic          clear_buffer0,
    input  logic          clear_buffer1,
    output logic          ddr3_rd_buffer0_empty,
    output logic          ddr3_rd_buffer1_empty,
    output logic          ddr3_avl_burstbegin,
    output logic          ddr3_avl_write_req,
    output logic [2:0]    ddr3_avl_size,
    output logic [25:0]   ddr3_avl_addr,
    output logic [127:0]  ddr3_avl_wdata,
    output logic [15:0]   ddr3_avl_be,
    input  logic          ddr3_avl_ready,
    output logic [15:0]   frames_written,
    output logic [15:0]   frames_dropped,
    output logic          busy
);

    localparam int PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int BURSTS = PIXELS >> 4;
    localparam int WORDS  = PIXELS >> 2;
    localparam int CW     = $clog2(WORDS + 1);
    localparam logic [CW-1:0] LAST_BURST = CW'(BURSTS - 1);
    localparam logic [CW-1:0] LAST_WORD  = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        BURST,
        DROP
    } state_t;

    state_t          r_state;
    logic            r_wr_sel;
    logic            r_full0;
    logic            r_full1;
    logic            r_empty0;
    logic            r_empty1;
    logic [25:0]     r_addr;
    logic [CW-1:0]   r_burst_cnt;
    logic [CW-1:0]   r_drop_cnt;
    logic [1:0]      r_beat;

    logic            w_accept;
    logic            w_frame_done;
    logic            w_drop_pop;
    logic            w_drop_done;
    logic            w_sel_full;
    logic            w_full0_nxt;
    logic            w_full1_nxt;

    assign w_accept     = (r_state == BURST) && ddr3_avl_ready;
    assign w_frame_done = w_accept && (r_beat == 2'd3)
                          && (r_burst_cnt == LAST_BURST);
    assign w_drop_pop   = (r_state == DROP) && src_burst_avail;
    assign w_drop_done  = w_drop_pop && (r_drop_cnt == LAST_WORD);
    assign w_sel_full   = r_wr_sel ? r_full1 : r_full0;

    // A completing frame's set beats the reader's clear of the same buffer.
    assign w_full0_nxt = (w_frame_done && !r_wr_sel)
                         || (r_full0 && !clear_buffer0);
    assign w_full1_nxt = (w_frame_done && r_wr_sel)
                         || (r_full1 && !clear_buffer1);

    assign ddr3_avl_write_req    = (r_state == BURST);
    assign ddr3_avl_burstbegin   = (r_state == BURST) && (r_beat == 2'd0);
    assign ddr3_avl_size         = 3'b100;
    assign ddr3_avl_be           = 16'hFFFF;
    assign ddr3_avl_addr         = r_addr;
    assign ddr3_avl_wdata        = src_data;
    assign src_rd                = w_accept || w_drop_pop;
    assign busy                  = (r_state != IDLE);
    assign ddr3_rd_buffer0_empty = r_empty0;
    assign ddr3_rd_buffer1_empty = r_empty1;

`ifdef WRITE_FRAME_STATS_EN
    logic [15:0] r_frames_written;
    logic [15:0] r_frames_dropped;
    assign frames_written = r_frames_written;
    assign frames_dropped = r_frames_dropped;
`else
    assign frames_written = 16'd0;
    assign frames_dropped = 16'd0;
`endif

    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            r_state     <= IDLE;
            r_wr_sel    <= 1'b0;
            r_full0     <= 1'b0;
            r_full1     <= 1'b0;
            r_empty0    <= 1'b1;
            r_empty1    <= 1'b1;
            r_addr      <= 26'd0;
            r_burst_cnt <= '0;
            r_drop_cnt  <= '0;
            r_beat      <= 2'd0;
`ifdef WRITE_FRAME_STATS_EN
            r_frames_written <= 16'd0;
            r_frames_dropped <= 16'd0;
`endif
        end else begin
            r_full0  <= w_full0_nxt;
            r_full1  <= w_full1_nxt;
            r_empty0 <= !w_full0_nxt;
            r_empty1 <= !w_full1_nxt;
            unique case (r_state)
                IDLE: begin
                    if (src_sof) begin
                        if (!w_sel_full) begin
                            r_addr      <= r_wr_sel ? ddr3_buffer1_offset
                                                    : ddr3_buffer0_offset;
                            r_burst_cnt <= '0;
                            r_beat      <= 2'd0;
                            r_state     <= WAIT_DATA;
                        end else begin
                            r_drop_cnt <= '0;
                            r_state    <= DROP;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (src_burst_avail)
                        r_state <= BURST;
                end
                BURST: begin
                    if (w_accept) begin
                        r_beat <= r_beat + 2'd1;
                        if (w_frame_done) begin
                            r_wr_sel <= !r_wr_sel;
`ifdef WRITE_FRAME_STATS_EN
                            r_frames_written <= r_frames_written + 16'd1;
`endif
                            r_state  <= IDLE;
                        end else if (r_beat == 2'd3) begin
                            r_addr      <= r_addr + 26'd4;
                            r_burst_cnt <= r_burst_cnt + CW'(1);
                            r_state     <= WAIT_DATA;
                        end
                    end
                end
                DROP: begin
                    if (w_drop_pop) begin
                        r_drop_cnt <= r_drop_cnt + CW'(1);
                        if (w_drop_done) begin
`ifdef WRITE_FRAME_STATS_EN
                            r_frames_dropped <= r_frames_dropped + 16'd1;
`endif
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_write_frame_to_ddr3.sv
// Self-checking bench for write_frame_to_ddr3 with a 16x4 frame (4 bursts).
// Source FIFO and expected Avalon beats are modelled with queues.
module tb_write_frame_to_ddr3;

`ifdef WRITE_FRAME_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          src_sof;
    logic          src_burst_avail;
    logic [127:0]  src_data;
    logic          src_rd;
    logic          clear0;
    logic          clear1;
    logic          e0;
    logic          e1;
    logic          bb;
    logic          wreq;
    logic [2:0]    size;
    logic [25:0]   addr;
    logic [127:0]  wdata;
    logic [15:0]   be;
    logic          ready;
    logic [15:0]   fw;
    logic [15:0]   fd;
    logic          busy;

    always #5 clk = ~clk;

    write_frame_to_ddr3 #(
        .IMAGE_WIDTH (16),
        .IMAGE_HEIGHT(4)
    ) dut (
        .ddr3_clk             (clk),
        .ddr3_reset_n         (rst_n),
        .src_sof              (src_sof),
        .src_burst_avail      (src_burst_avail),
        .src_data             (src_data),
        .src_rd               (src_rd),
        .ddr3_buffer0_offset  (26'h100),
        .ddr3_buffer1_offset  (26'h800),
        .clear_buffer0        (clear0),
        .clear_buffer1        (clear1),
        .ddr3_rd_buffer0_empty(e0),
        .ddr3_rd_buffer1_empty(e1),
        .ddr3_avl_burstbegin  (bb),
        .ddr3_avl_write_req   (wreq),
        .ddr3_avl_size        (size),
        .ddr3_avl_addr        (addr),
        .ddr3_avl_wdata       (wdata),
        .ddr3_avl_be          (be),
        .ddr3_avl_ready       (ready),
        .frames_written       (fw),
        .frames_dropped       (fd),
        .busy                 (busy)
    );

    typedef struct {
        logic [25:0]  addr;
        logic [127:0] data;
        int           beat;
        bit           last;
        bit           bufn;
    } exp_t;

    typedef struct {
        bit          clr0;
        bit          clr1;
        bit          tog;
        bit          drop;
        logic [25:0] base;
        bit          e0;
        bit          e1;
    } row_t;

    logic [127:0] fifo[$];
    exp_t         sb[$];
    row_t         rows[5];
    int           n_checks = 0;
    int           n_fail = 0;
    int           pops;
    int           n_acc;
    bit           tog;
    bit           last_pending;
    bit           last_buf;
    logic [15:0]  m_wr;
    logic [15:0]  m_drop;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        src_burst_avail = (fifo.size() >= 4);
        src_data = (fifo.size() > 0) ? fifo[0] : '0;
    endtask

    task automatic cyc();
        bit   pop;
        exp_t e;
        @(negedge clk);
        pop = src_rd;
        if (last_pending) begin
            check("empty_fall", last_buf ? e1 : e0, 0);
            last_pending = 0;
        end
        if (wreq) begin
            if (sb.size() == 0) begin
                check("unexpected_write_req", wreq, 0);
            end else begin
                e = sb[0];
                check("burstbegin", bb, (e.beat == 0));
                check("addr", addr, e.addr);
                check("size_be", {size, be}, {3'b100, 16'hFFFF});
                if (ready) begin
                    check("wdata", wdata, e.data);
                    check("src_rd_accept", pop, 1);
                    if (e.last) begin
                        check("empty_before_full", e.bufn ? e1 : e0, 1);
                        last_pending = 1;
                        last_buf = e.bufn;
                    end
                    void'(sb.pop_front());
                    n_acc++;
                end else begin
                    check("src_rd_stall", pop, 0);
                end
            end
        end
        if (pop) pops++;
        @(posedge clk);
        #1;
        if (pop && fifo.size() > 0) void'(fifo.pop_front());
        if (tog) ready = !ready;
        refresh();
    endtask

    task automatic push_frame(logic [25:0] base, bit bufn, bit wr);
        logic [127:0] w;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            fifo.push_back(w);
            if (wr) begin
                e.addr = base + 26'(4 * (i / 4));
                e.data = w;
                e.beat = i % 4;
                e.last = (i == 15);
                e.bufn = bufn;
                sb.push_back(e);
            end
        end
        if (!wr) begin
            for (int i = 0; i < 3; i++) fifo.push_back(128'(i + 1));
        end
        refresh();
    endtask

    task automatic run_frame(row_t r);
        bit done;
        if (r.clr0) begin
            clear0 = 1;
            check("empty0_before_clear", e0, 0);
            cyc();
            clear0 = 0;
            check("empty0_after_clear", e0, 1);
        end
        if (r.clr1) begin
            clear1 = 1;
            check("empty1_before_clear", e1, 0);
            cyc();
            clear1 = 0;
            check("empty1_after_clear", e1, 1);
        end
        pops = 0;
        n_acc = 0;
        ready = 1;
        tog = r.tog;
        src_sof = 1;
        cyc();
        src_sof = 0;
        check("busy_after_sof", busy, 1);
        push_frame(r.base, (r.base == 26'h800), !r.drop);
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            cyc();
            if (!busy) done = 1;
        end
        check("frame_timeout", done, 1);
        cyc();
        tog = 0;
        ready = 1;
        if (r.drop) m_drop++;
        else m_wr++;
        check("pops", pops, 16);
        check("beats_accepted", n_acc, r.drop ? 0 : 16);
        check("sb_left", sb.size(), 0);
        check("empty0", e0, r.e0);
        check("empty1", e1, r.e1);
        check("frames_written", fw, STATS ? m_wr : 16'd0);
        check("frames_dropped", fd, STATS ? m_drop : 16'd0);
        fifo.delete();
        sb.delete();
        refresh();
    endtask

    initial begin
        bit done;
        rows[0] = '{0, 0, 0, 0, 26'h100, 0, 1};
        rows[1] = '{0, 0, 1, 0, 26'h800, 0, 0};
        rows[2] = '{0, 0, 0, 1, 26'h000, 0, 0};
        rows[3] = '{1, 0, 0, 0, 26'h100, 0, 0};
        rows[4] = '{0, 1, 0, 0, 26'h800, 0, 0};
        m_wr = 0;
        m_drop = 0;
        tog = 0;
        last_pending = 0;
        last_buf = 0;
        rst_n = 0;
        src_sof = 0;
        clear0 = 0;
        clear1 = 0;
        ready = 1;
        refresh();
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {wreq, bb, src_rd, busy}, 4'b0000);
        check("rst_empty", {e0, e1}, 2'b11);
        check("rst_addr", addr, 0);
        check("rst_counters", {fw, fd}, 0);
        rst_n = 1;
        cyc();

        for (int i = 0; i < 5; i++) run_frame(rows[i]);

        // Reset in the middle of the second burst of a buffer0 frame.
        clear0 = 1;
        cyc();
        clear0 = 0;
        n_acc = 0;
        src_sof = 1;
        cyc();
        src_sof = 0;
        push_frame(26'h100, 0, 1);
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            cyc();
            if (n_acc >= 6) done = 1;
        end
        check("reach_burst2", done, 1);
        check("mid_burst_busy", wreq, 1);
        #2;
        rst_n = 0;
        #1;
        check("arst_outputs", {wreq, bb, src_rd, busy}, 4'b0000);
        check("arst_empty", {e0, e1}, 2'b11);
        check("arst_addr", addr, 0);
        check("arst_counters", {fw, fd}, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        sb.delete();
        fifo.delete();
        refresh();
        last_pending = 0;
        m_wr = 0;
        m_drop = 0;
        run_frame(rows[0]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/write_frame_to_ddr3.md
WRITE_FRAME_TO_DDR3 -- requirements
Module: write_frame_to_ddr3

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 1280, pixels per line (32-bit pixels, four per 128-bit word).
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 1024, lines per frame; IMAGE_WIDTH*IMAGE_HEIGHT SHALL be a multiple of 16.
REQ-003 SHALL have ports ddr3_clk in 1, clock (all logic); ddr3_reset_n in 1, reset, asynchronous, active-low.
REQ-004 SHALL have ports src_sof in 1, start-of-frame pulse; src_burst_avail in 1, source show-ahead FIFO holds >=4 words; src_data in 128, FIFO head word; src_rd out 1, pop.
REQ-005 SHALL have ports ddr3_buffer0_offset in 26, ddr3_buffer1_offset in 26, word base address of each frame buffer.
REQ-006 SHALL have ports clear_buffer0 in 1, clear_buffer1 in 1, single-cycle "buffer consumed" pulses from the reader.
REQ-007 SHALL have ports ddr3_rd_buffer0_empty out 1, ddr3_rd_buffer1_empty out 1, buffer holds no unread frame.
REQ-008 SHALL have Avalon outputs ddr3_avl_burstbegin 1, ddr3_avl_write_req 1, ddr3_avl_size 3, ddr3_avl_addr 26, ddr3_avl_wdata 128, ddr3_avl_be 16; input ddr3_avl_ready 1.
REQ-009 SHALL have outputs frames_written 16, frames_dropped 16, busy 1.

Function
REQ-010 SHALL use BURSTS = (IMAGE_WIDTH*IMAGE_HEIGHT)>>4 bursts per frame, each 4 beats, ddr3_avl_size = 3'b100, ddr3_avl_be = 16'hFFFF.
REQ-011 SHALL implement states IDLE, WAIT_DATA, BURST, DROP; busy = state != IDLE.
REQ-012 IDLE: on src_sof, if buffer wr_sel is empty -> load addr with its offset, burst count 0, go WAIT_DATA; else -> DROP with word count 0; src_sof outside IDLE SHALL be ignored.
REQ-013 WAIT_DATA: when src_burst_avail -> BURST; no Avalon request asserted in WAIT_DATA.
REQ-014 BURST: ddr3_avl_write_req high every cycle; ddr3_avl_burstbegin high only on beat 0 until accepted; beat accepted when write_req && ready.
REQ-015 src_rd SHALL equal beat accepted in BURST; ddr3_avl_wdata = src_data combinationally; addr held constant for the whole burst.
REQ-016 After beat 3 accepted: if burst count == BURSTS-1 -> mark buffer wr_sel full, toggle wr_sel, increment frames_written, go IDLE; else addr += 4, count += 1, go WAIT_DATA.
REQ-017 DROP: pop one word per cycle while src_burst_avail until IMAGE_WIDTH*IMAGE_HEIGHT/4 words discarded, then increment frames_dropped, go IDLE; no Avalon activity, wr_sel unchanged.
REQ-018 Buffer full flag SHALL set the cycle after the frame's last beat is accepted; clear_bufferN SHALL clear flag N the following cycle; simultaneous set and clear of the same flag -> set wins.
REQ-019 ddr3_rd_bufferN_empty SHALL be the registered inverse of full flag N.
REQ-020 Counters SHALL wrap modulo 2^16; addr arithmetic modulo 2^26.
REQ-021 ddr3_avl_ready low mid-burst SHALL stall without skipping or repeating beats or pops.

Reset
REQ-022 On ddr3_reset_n low at any time: state IDLE, wr_sel 0, both full flags 0 (both empty outputs 1), addr 0, counts 0, counters 0, write_req/burstbegin/src_rd 0; a partially written frame SHALL not be marked full.

Configuration
REQ-023 With WRITE_FRAME_STATS_EN defined, frames_written and frames_dropped SHALL count per REQ-016/REQ-017; without it both SHALL be tied to 0 and their registers omitted, all other behaviour identical.

Verification
REQ-024 W=16,H=4, offsets 0x100/0x800, ready=1, sof then 16 words -> 4 bursts at addr 0x100,0x104,0x108,0x10C; buffer0_empty falls 1 cycle after last beat; wr_sel=1.
REQ-025 Second frame -> bursts at 0x800..0x80C, buffer1_empty falls; third sof with buffer0 still full -> DROP, 16 words popped, no write_req, frames_dropped=1.
REQ-026 ready toggles 1,0,1,0 during a burst -> exactly 4 accepted beats, 4 src_rd pulses, wdata matches FIFO order, burstbegin only on first beat.
REQ-027 clear_buffer0 pulse -> buffer0_empty rises next cycle; next sof writes buffer0 at 0x100.
REQ-028 Reset asserted during burst 2 -> all outputs at reset values, both empty flags 1, next sof restarts at buffer0 offset 0x100.
